// File: rtl/crc_pkg.sv
// Shared CRC-8 definitions: FSM state type, default polynomial and the
// single-bit update function used by both the datapath and the bench model.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    // One MSB-first shift of the CRC register with data bit b.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b,
                                             input logic [7:0] poly);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_bit_step.sv
// Combinational single-bit CRC-8 update: feedback XOR of register MSB and
// data bit, folded into the shifted register through the polynomial taps.
module crc8_bit_step #(
    parameter logic [7:0] POLY = 8'h07
) (
    input  logic [7:0] crc_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic fb;

    assign fb    = crc_i[7] ^ bit_i;
    assign crc_o = {crc_i[6:0], 1'b0} ^ ({8{fb}} & POLY);

endmodule

// File: rtl/serial_crc8.sv
// Bit-serial CRC-8 generator/checker with framing FSM, saturating bit counter,
// mid-frame abort detection and a one-cycle completion pulse.
module serial_crc8
    import crc_pkg::*;
#(
    parameter logic [7:0] POLY  = CRC8_POLY,
    parameter logic [7:0] INIT  = 8'h00,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             sof,
    input  logic             eof,
    output logic [7:0]       crc_out,
    output logic             crc_valid,
    output logic [LEN_W-1:0] bit_count,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow
);

    localparam logic [LEN_W-1:0] CNT_MAX = '1;
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    state_e           state_q, state_d;
    logic [7:0]       crc_q, crc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             frame_err_q, frame_err_d;
    logic             ovf_q, ovf_d;

    logic       start;
    logic [7:0] step_in;
    logic [7:0] step_out;

    assign start = bit_valid & sof;
    // A start-of-frame bit always folds into INIT, never the live register.
    assign step_in = start ? INIT : crc_q;

    crc8_bit_step #(
        .POLY (POLY)
    ) u_step (
        .crc_i (step_in),
        .bit_i (bit_in),
        .crc_o (step_out)
    );

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        frame_err_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bit_valid) begin
                    crc_d = step_out;
                    if (sof) begin
                        frame_err_d = 1'b1;
                        cnt_d       = CNT_ONE;
                        ovf_d       = 1'b0;
                        state_d     = eof ? DONE : RUN;
                    end else begin
                        if (cnt_q == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                        if (eof) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    crc_d   = step_out;
                    cnt_d   = CNT_ONE;
                    ovf_d   = 1'b0;
                    state_d = eof ? DONE : RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign crc_out   = crc_q;
    assign bit_count = cnt_q;
    assign crc_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign frame_err = frame_err_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_crc8.sv
// Bench for serial_crc8: directed framing scenarios plus randomized frames
// compared against a bit-queue CRC model; a LEN_W=3 copy covers saturation.
module tb_serial_crc8;
    import crc_pkg::*;

    typedef logic bitq_t[$];
    typedef logic [7:0] byteq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       sof;
    logic       eof;
    logic [7:0] crc_out;
    logic       crc_valid;
    logic [7:0] bit_count;
    logic       busy;
    logic       frame_err;
    logic       overflow;
    logic [7:0] crc_out_s;
    logic       crc_valid_s;
    logic [2:0] bit_count_s;
    logic       busy_s;
    logic       frame_err_s;
    logic       overflow_s;

    int tests = 0;
    int fails = 0;
    int fe_seen = 0;

    always #5 clk = ~clk;

    serial_crc8 dut (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .sof       (sof),
        .eof       (eof),
        .crc_out   (crc_out),
        .crc_valid (crc_valid),
        .bit_count (bit_count),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    serial_crc8 #(
        .LEN_W (3)
    ) dut_small (
        .clk       (clk),
        .rst       (rst),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .sof       (sof),
        .eof       (eof),
        .crc_out   (crc_out_s),
        .crc_valid (crc_valid_s),
        .bit_count (bit_count_s),
        .busy      (busy_s),
        .frame_err (frame_err_s),
        .overflow  (overflow_s)
    );

    function automatic bitq_t to_bits(input byteq_t bytes);
        bitq_t q;
        foreach (bytes[i]) begin
            for (int k = 7; k >= 0; k--) q.push_back(bytes[i][k]);
        end
        return q;
    endfunction

    function automatic logic [7:0] model_crc(input bitq_t q);
        logic [7:0] c;
        c = 8'h00;
        foreach (q[i]) c = crc8_step(c, q[i], CRC8_POLY);
        return c;
    endfunction

    task automatic send_bit(input logic b, input logic s, input logic e);
        bit_in = b; sof = s; eof = e; bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_in = 1'b0; sof = 1'b0; eof = 1'b0; bit_valid = 1'b0;
        if (frame_err) fe_seen++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (frame_err) fe_seen++;
        end
    endtask

    task automatic send_bits(input bitq_t q, input int gap, output int busy_bad);
        busy_bad = 0;
        foreach (q[i]) begin
            send_bit(q[i], i == 0, i == q.size() - 1);
            if (i != q.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    idle(1);
                    if (busy !== 1'b1) busy_bad++;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        tests++;
        if ({crc_out, crc_valid, bit_count, busy, frame_err, overflow} !== 20'h0) begin
            fails++;
            $display("FAIL reset_outputs: got crc=%h v=%b cnt=%0d busy=%b fe=%b ovf=%b, want all zero",
                     crc_out, crc_valid, bit_count, busy, frame_err, overflow);
        end
        rst = 1'b0;
        idle(1);
        tests++;
        if (crc_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got v=%b busy=%b, want 0 0", crc_valid, busy);
        end
    endtask

    task automatic test_single_byte;
        byteq_t b;
        int bb;
        b = '{8'h80};
        send_bits(to_bits(b), 0, bb);
        tests++;
        if (crc_valid !== 1'b1 || crc_out !== 8'h89 || bit_count !== 8'd8) begin
            fails++;
            $display("FAIL byte_80: got v=%b crc=%h cnt=%0d, want 1 89 8", crc_valid, crc_out, bit_count);
        end
        idle(2);
        tests++;
        if (crc_valid !== 1'b0 || crc_out !== 8'h89 || busy !== 1'b0) begin
            fails++;
            $display("FAIL byte_80_hold: got v=%b crc=%h busy=%b, want 0 89 0", crc_valid, crc_out, busy);
        end
    endtask

    task automatic test_check_string;
        byteq_t b;
        int bb;
        b = {};
        for (int i = 0; i < 9; i++) b.push_back(8'h31 + 8'(i));
        send_bits(to_bits(b), 0, bb);
        tests++;
        if (crc_valid !== 1'b1 || crc_out !== 8'hF4 || bit_count !== 8'd72) begin
            fails++;
            $display("FAIL check_string: got v=%b crc=%h cnt=%0d, want 1 f4 72", crc_valid, crc_out, bit_count);
        end
        idle(1);
        b.push_back(8'hF4);
        send_bits(to_bits(b), 0, bb);
        tests++;
        if (crc_valid !== 1'b1 || crc_out !== 8'h00 || bit_count !== 8'd80) begin
            fails++;
            $display("FAIL check_residue: got v=%b crc=%h cnt=%0d, want 1 00 80", crc_valid, crc_out, bit_count);
        end
        idle(1);
    endtask

    task automatic test_gaps;
        byteq_t b;
        int bb;
        b = '{8'h01};
        send_bits(to_bits(b), 3, bb);
        tests++;
        if (crc_valid !== 1'b1 || crc_out !== 8'h07 || bit_count !== 8'd8) begin
            fails++;
            $display("FAIL gaps_crc: got v=%b crc=%h cnt=%0d, want 1 07 8", crc_valid, crc_out, bit_count);
        end
        tests++;
        if (bb !== 0) begin
            fails++;
            $display("FAIL gaps_busy: got %0d idle cycles with busy low, want 0", bb);
        end
        idle(1);
    endtask

    task automatic test_abort;
        byteq_t b;
        int bb;
        fe_seen = 0;
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0, 1'b0);
        b = '{8'h80};
        send_bits(to_bits(b), 0, bb);
        tests++;
        if (crc_valid !== 1'b1 || crc_out !== 8'h89 || bit_count !== 8'd8) begin
            fails++;
            $display("FAIL abort_crc: got v=%b crc=%h cnt=%0d, want 1 89 8", crc_valid, crc_out, bit_count);
        end
        idle(2);
        tests++;
        if (fe_seen !== 1) begin
            fails++;
            $display("FAIL abort_frame_err: got %0d pulses, want 1", fe_seen);
        end
    endtask

    task automatic test_back_to_back;
        byteq_t a, b;
        int bb;
        a = '{8'($urandom)};
        b = '{8'($urandom), 8'($urandom)};
        send_bits(to_bits(a), 0, bb);
        tests++;
        if (crc_valid !== 1'b1 || crc_out !== model_crc(to_bits(a))) begin
            fails++;
            $display("FAIL b2b_first: got v=%b crc=%h, want 1 %h", crc_valid, crc_out, model_crc(to_bits(a)));
        end
        send_bits(to_bits(b), 0, bb);
        tests++;
        if (crc_valid !== 1'b1 || crc_out !== model_crc(to_bits(b)) || bit_count !== 8'd16) begin
            fails++;
            $display("FAIL b2b_second: got v=%b crc=%h cnt=%0d, want 1 %h 16",
                     crc_valid, crc_out, bit_count, model_crc(to_bits(b)));
        end
        send_bit(1'b1, 1'b1, 1'b1);
        tests++;
        if (crc_valid !== 1'b1 || crc_out !== 8'h07 || bit_count !== 8'd1) begin
            fails++;
            $display("FAIL single_bit: got v=%b crc=%h cnt=%0d, want 1 07 1", crc_valid, crc_out, bit_count);
        end
        idle(1);
    endtask

    task automatic test_random;
        bitq_t q;
        int bb;
        int bad;
        logic [7:0] exp;
        bad = 0;
        for (int f = 0; f < 20; f++) begin
            q = {};
            for (int i = 0, n = int'($urandom_range(40, 1)); i < n; i++) q.push_back(1'($urandom));
            exp = model_crc(q);
            send_bits(q, int'($urandom_range(2, 0)), bb);
            if (crc_valid !== 1'b1 || crc_out !== exp || bit_count !== 8'(q.size()) || bb != 0) begin
                bad++;
                $display("FAIL random_frame_%0d: got v=%b crc=%h cnt=%0d busy_gaps=%0d, want 1 %h %0d 0",
                         f, crc_valid, crc_out, bit_count, bb, exp, q.size());
            end
            idle(int'($urandom_range(2, 0)));
        end
        tests++;
        if (bad != 0) fails++;
        idle(1);
    endtask

    task automatic test_overflow;
        bitq_t q;
        int bb;
        q = {};
        for (int i = 0; i < 9; i++) q.push_back(1'($urandom));
        send_bits(q, 0, bb);
        tests++;
        if (bit_count_s !== 3'd7 || overflow_s !== 1'b1 || crc_out_s !== model_crc(q)) begin
            fails++;
            $display("FAIL overflow_small: got cnt=%0d ovf=%b crc=%h, want 7 1 %h",
                     bit_count_s, overflow_s, crc_out_s, model_crc(q));
        end
        tests++;
        if (bit_count !== 8'd9 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL overflow_wide: got cnt=%0d ovf=%b, want 9 0", bit_count, overflow);
        end
        idle(3);
        tests++;
        if (overflow_s !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sticky: got %b, want 1", overflow_s);
        end
        send_bit(1'b1, 1'b1, 1'b0);
        tests++;
        if (overflow_s !== 1'b0 || bit_count_s !== 3'd1) begin
            fails++;
            $display("FAIL overflow_clear: got ovf=%b cnt=%0d, want 0 1", overflow_s, bit_count_s);
        end
        send_bit(1'b0, 1'b0, 1'b1);
        idle(1);
    endtask

    task automatic test_reset_mid;
        int vseen;
        vseen = 0;
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), i == 0, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        tests++;
        if ({crc_out, crc_valid, bit_count, busy, frame_err, overflow} !== 20'h0) begin
            fails++;
            $display("FAIL reset_mid: got crc=%h v=%b cnt=%0d busy=%b fe=%b ovf=%b, want all zero",
                     crc_out, crc_valid, bit_count, busy, frame_err, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (crc_valid !== 1'b0) vseen++;
        end
        tests++;
        if (vseen != 0) begin
            fails++;
            $display("FAIL reset_mid_valid: got %0d crc_valid cycles, want 0", vseen);
        end
    endtask

    initial begin
        rst = 1'b1;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        sof = 1'b0;
        eof = 1'b0;
        test_reset();
        test_single_byte();
        test_check_string();
        test_gaps();
        test_abort();
        test_back_to_back();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_crc8.md
Name: serial_crc8

Overview:
- Bit-serial CRC-8 generator/checker. Each data bit is XOR-combined with the register MSB, so it is built from the 2-input XOR primitive plus state.
- Sits downstream of a bit source such as a shift register or UART receiver. Accumulates one framed bit per valid cycle.
- Presents the final CRC with a one-cycle done pulse.
- Used for both generation and checking: a frame that includes its own CRC yields crc_out = 0.

Parameters:
- POLY, 8'h07, generator polynomial with the implicit x^8 term omitted.
- INIT, 8'h00, register value loaded at start of frame.
- LEN_W, 8, width of the frame bit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit, MSB-first.
- bit_valid  input  1  bit_in is consumed this cycle.
- sof  input  1  start-of-frame; qualified by bit_valid, marks the first bit.
- eof  input  1  end-of-frame; qualified by bit_valid, marks the last bit.
- crc_out  output  8  CRC register; holds the final value after the frame.
- crc_valid  output  1  one-cycle pulse the cycle after the eof bit is consumed.
- bit_count  output  LEN_W  number of bits consumed in the current/last frame.
- busy  output  1  high while in state RUN.
- frame_err  output  1  one-cycle pulse on sof received mid-frame (frame aborted).
- overflow  output  1  sticky: bit_count saturated; cleared on next sof.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, crc_out=INIT, crc_valid=0, bit_count=0, busy=0, frame_err=0, overflow=0. Reset mid-frame discards the frame with no crc_valid.
- Update rule, per consumed bit b, starting from c: fb = c[7] ^ b; next = {c[6:0],1'b0} ^ (fb ? POLY : 8'h00).
- On sof, c is INIT regardless of the current register.
- States:
  - IDLE: bit_valid&sof -> load INIT, apply bit, bit_count=1, go to RUN. If eof is also set (single-bit frame), go to DONE instead. bit_valid without sof is ignored; no change.
  - RUN: bit_valid&!sof -> apply bit, bit_count+1; eof -> DONE. bit_valid&sof -> frame_err pulse next cycle, restart as in IDLE (INIT, count=1). Cycles without bit_valid hold all state.
  - DONE: lasts exactly one cycle with crc_valid=1, then goes to IDLE. An input bit in DONE is handled exactly as in IDLE (sof starts a new frame with no bubble).
- Latency: crc_out is final and crc_valid=1 in the cycle after the eof bit.
- crc_out holds its value until the next sof is consumed.
- bit_count saturates at 2^LEN_W-1. A further consumed bit sets overflow, and the CRC continues to update normally.
- eof with sof in RUN: abort and complete a 1-bit frame; frame_err and crc_valid pulse in the same cycle.
- eof without sof in IDLE/DONE: ignored.

Decomposition:
- Shared package crc_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - constant CRC8_POLY=8'h07;
  - function crc8_step(c, b, poly) implementing the update rule, reused by the bench model.
- One sub-module is natural: crc8_bit_step, the combinational single-bit update built from the XOR gate. The FSM and counters stay in the top.

Test Plan:
- rst then frame 0x80 (8 bits, MSB-first, sof on bit 1, eof on bit 8) -> next cycle crc_valid=1, crc_out=8'h89, bit_count=8.
- ASCII "123456789" (72 bits, contiguous) -> crc_out=8'hF4, bit_count=72; then frame 0x31..0x39 followed by byte 0xF4 -> crc_out=8'h00.
- Frame 0x01 with bit_valid low for 3 cycles between every bit -> crc_out=8'h07, identical to the contiguous case, busy high throughout.
- Mid-frame sof after 5 bits of 0xFF, then a full 0x80 frame -> frame_err pulse once, final crc_out=8'h89, bit_count=8.
- Back-to-back: eof of frame A, with sof of frame B in the DONE cycle -> crc_valid for A, B's CRC correct; single-bit frame (sof&eof, bit 1) -> crc_out=8'h07, bit_count=1.
- LEN_W=3 with a 9-bit frame -> bit_count=7, overflow=1 and held until next sof; rst asserted mid-frame -> no crc_valid, all outputs at reset values.
